// File: rtl/brick_game_pkg.sv
// Shared types and constants for the brick-breaker game sequencer.
package brick_game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOSE  = 3'd3,
        WIN   = 3'd4
    } game_state_e;

    localparam int BONUS_STEP = 100;

    // Bits needed to hold a lives count of 0..max_lives.
    function automatic int lives_width(input int max_lives);
        return (max_lives < 1) ? 1 : $clog2(max_lives + 1);
    endfunction

endpackage

// File: rtl/brick_score_acc.sv
// Score accumulator: counts bricks cleared this cycle, weights them by (level+1)
// and adds to the running score, saturating at all-ones.
module brick_score_acc #(
    parameter int NUM_BRICKS = 6,
    parameter int SCORE_W    = 12
) (
    input  logic [NUM_BRICKS-1:0] cleared,
    input  logic [2:0]            level,
    input  logic [SCORE_W-1:0]    score_in,
    output logic [SCORE_W-1:0]    score_out
);
    localparam int CW = $clog2(NUM_BRICKS + 1);
    localparam int AW = SCORE_W + 4;

    logic [CW-1:0] cnt;
    logic [3:0]    weight;
    logic [AW-1:0] sum;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            cnt = cnt + CW'(cleared[i]);
        end
        weight = {1'b0, level} + 4'd1;
        sum    = AW'(score_in) + AW'(cnt) * AW'(weight);
        if (sum > AW'({SCORE_W{1'b1}})) begin
            score_out = '1;
        end else begin
            score_out = sum[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/brick_game_ctrl.sv
// Game sequencer for brick-breaker: lives, levels, scoring, serve timing, restart.
// Optional bonus lives enabled by defining BRICK_BONUS_LIFE_EN.
module brick_game_ctrl
    import brick_game_pkg::*;
#(
    parameter int NUM_BRICKS  = 6,
    parameter int MAX_LIVES   = 3,
    parameter int NUM_LEVELS  = 3,
    parameter int SERVE_DELAY = 25000000,
    parameter int SCORE_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_n,
    input  logic [NUM_BRICKS-1:0] brick_exist,
    input  logic [NUM_BRICKS-1:0] brick_death_zone,
    input  logic                  ball_lost,
    output logic                  play_en,
    output logic                  ball_serve,
    output logic                  field_reset,
    output logic [2:0]            lives,
    output logic [2:0]            level,
    output logic [SCORE_W-1:0]    score,
    output logic                  game_over,
    output logic                  victory,
    output logic [2:0]            state
);
    localparam int LW    = lives_width(MAX_LIVES);
    localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    game_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]         lives_q, lives_d;
    logic [2:0]            level_q, level_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic                  start_prev_q;
    logic [NUM_BRICKS-1:0] prev_exist_q;
    logic                  play_en_q, play_en_d;
    logic                  ball_serve_q, ball_serve_d;
    logic                  field_reset_q, field_reset_d;
    logic                  game_over_q, game_over_d;
    logic                  victory_q, victory_d;

    logic                  start_press;
    logic [NUM_BRICKS-1:0] cleared;
    logic [SCORE_W-1:0]    score_upd;

    // Only falling exist bits seen during PLAY score; respawns are rising edges.
    assign start_press = start_prev_q & ~start_n;
    assign cleared     = (state_q == PLAY) ? (prev_exist_q & ~brick_exist) : '0;

    brick_score_acc #(
        .NUM_BRICKS(NUM_BRICKS),
        .SCORE_W   (SCORE_W)
    ) u_score_acc (
        .cleared  (cleared),
        .level    (level_q),
        .score_in (score_q),
        .score_out(score_upd)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        lives_d       = lives_q;
        level_d       = level_q;
        score_d       = score_upd;
        ball_serve_d  = 1'b0;
        field_reset_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_press) begin
                    state_d       = SERVE;
                    field_reset_d = 1'b1;
                end
            end
            SERVE: begin
                if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
                    state_d      = PLAY;
                    ball_serve_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PLAY: begin
                if (|brick_death_zone) begin
                    state_d = LOSE;
                end else if (ball_lost) begin
                    if (lives_q == LW'(1)) begin
                        lives_d = '0;
                        state_d = LOSE;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        state_d = SERVE;
                    end
                end else if (brick_exist == '0) begin
                    if (level_q == 3'(NUM_LEVELS - 1)) begin
                        state_d = WIN;
                    end else begin
                        level_d       = level_q + 3'd1;
                        field_reset_d = 1'b1;
                        state_d       = SERVE;
                    end
                end
            end
            LOSE, WIN: begin
                if (start_press) begin
                    field_reset_d = 1'b1;
                    lives_d       = LW'(MAX_LIVES);
                    level_d       = '0;
                    score_d       = '0;
                    state_d       = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BRICK_BONUS_LIFE_EN
        // One bonus life per threshold crossing, never in a cycle that loses a life.
        if ((state_q == PLAY) && !((~|brick_death_zone) && ball_lost) &&
            ((int'(score_upd) / BONUS_STEP) != (int'(score_q) / BONUS_STEP)) &&
            (lives_d < LW'(MAX_LIVES))) begin
            lives_d = lives_d + 1'b1;
        end
`endif
        play_en_d   = (state_d == PLAY);
        game_over_d = (state_d == LOSE);
        victory_d   = (state_d == WIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lives_q       <= LW'(MAX_LIVES);
            level_q       <= '0;
            score_q       <= '0;
            start_prev_q  <= 1'b1;
            prev_exist_q  <= '1;
            play_en_q     <= 1'b0;
            ball_serve_q  <= 1'b0;
            field_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            victory_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            score_q       <= score_d;
            start_prev_q  <= start_n;
            prev_exist_q  <= brick_exist;
            play_en_q     <= play_en_d;
            ball_serve_q  <= ball_serve_d;
            field_reset_q <= field_reset_d;
            game_over_q   <= game_over_d;
            victory_q     <= victory_d;
        end
    end

    assign play_en     = play_en_q;
    assign ball_serve  = ball_serve_q;
    assign field_reset = field_reset_q;
    assign lives       = 3'(lives_q);
    assign level       = level_q;
    assign score       = score_q;
    assign game_over   = game_over_q;
    assign victory     = victory_q;
    assign state       = state_q;

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Self-checking bench for brick_game_ctrl: directed vector table, corner-case
// sequences and randomized play checked against a behavioural game model.
module tb_brick_game_ctrl;

    localparam int NB   = 6;
    localparam int ML   = 3;
    localparam int NL   = 2;
    localparam int SD   = 4;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_LOSE  = 3;
    localparam int S_WIN   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_n = 1'b1;
    logic [NB-1:0] brick_exist = '1;
    logic [NB-1:0] brick_death_zone = '0;
    logic          ball_lost = 1'b0;
    logic          play_en, ball_serve, field_reset, game_over, victory;
    logic [2:0]    lives, level, dut_state;
    logic [SW-1:0] score;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the game rules.
    int          m_state, m_lives, m_level, m_score, m_serve_left;
    bit          m_prev_start, m_fr, m_serve;
    bit [NB-1:0] m_prev_exist;

    typedef struct {
        logic          sn;
        logic [NB-1:0] ex;
        logic [NB-1:0] dz;
        logic          bl;
        int            st;
        int            lv;
        int            lvl;
        int            sc;
        logic          fr;
        logic          bs;
    } vec_t;

    vec_t tv[22];

    brick_game_ctrl #(
        .NUM_BRICKS (NB),
        .MAX_LIVES  (ML),
        .NUM_LEVELS (NL),
        .SERVE_DELAY(SD),
        .SCORE_W    (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_n         (start_n),
        .brick_exist     (brick_exist),
        .brick_death_zone(brick_death_zone),
        .ball_lost       (ball_lost),
        .play_en         (play_en),
        .ball_serve      (ball_serve),
        .field_reset     (field_reset),
        .lives           (lives),
        .level           (level),
        .score           (score),
        .game_over       (game_over),
        .victory         (victory),
        .state           (dut_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    endtask

    function automatic vec_t v(input logic sn, input logic [NB-1:0] ex, input logic [NB-1:0] dz,
                               input logic bl, input int st, input int lv, input int lvl,
                               input int sc, input logic fr, input logic bs);
        vec_t r;
        r.sn = sn; r.ex = ex; r.dz = dz; r.bl = bl; r.st = st; r.lv = lv;
        r.lvl = lvl; r.sc = sc; r.fr = fr; r.bs = bs;
        return r;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_lives = ML; m_level = 0; m_score = 0; m_serve_left = 0;
        m_prev_start = 1'b1; m_prev_exist = '1; m_fr = 1'b0; m_serve = 1'b0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit press;
        int gained;
        press  = m_prev_start && !start_n;
        gained = (m_state == S_PLAY) ? $countones(m_prev_exist & ~brick_exist) * (m_level + 1) : 0;
        m_score = (m_score + gained > SMAX) ? SMAX : m_score + gained;
        m_fr = 1'b0;
        m_serve = 1'b0;
        if (m_state == S_IDLE) begin
            if (press) begin m_state = S_SERVE; m_serve_left = SD; m_fr = 1'b1; end
        end else if (m_state == S_SERVE) begin
            if (m_serve_left == 1) begin m_state = S_PLAY; m_serve = 1'b1; end
            else m_serve_left--;
        end else if (m_state == S_PLAY) begin
            if (brick_death_zone != 0) m_state = S_LOSE;
            else if (ball_lost) begin
                m_lives--;
                if (m_lives == 0) m_state = S_LOSE;
                else begin m_state = S_SERVE; m_serve_left = SD; end
            end else if (brick_exist == 0) begin
                if (m_level == NL - 1) m_state = S_WIN;
                else begin
                    m_level++; m_fr = 1'b1; m_state = S_SERVE; m_serve_left = SD;
                end
            end
        end else if (press) begin
            m_fr = 1'b1; m_lives = ML; m_level = 0; m_score = 0;
            m_state = S_SERVE; m_serve_left = SD;
        end
        m_prev_start = start_n;
        m_prev_exist = brick_exist;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("state", int'(dut_state), m_state);
        chk("lives", int'(lives), m_lives);
        chk("level", int'(level), m_level);
        chk("score", int'(score), m_score);
        chk("play_en", int'(play_en), int'(m_state == S_PLAY));
        chk("game_over", int'(game_over), int'(m_state == S_LOSE));
        chk("victory", int'(victory), int'(m_state == S_WIN));
        chk("ball_serve", int'(ball_serve), int'(m_serve));
        chk("field_reset", int'(field_reset), int'(m_fr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start_n = 1'b1;
        brick_exist = '1;
        brick_death_zone = '0;
        ball_lost = 1'b0;
        model_reset();
        #2;
        chk("rst.state", int'(dut_state), S_IDLE);
        chk("rst.lives", int'(lives), ML);
        chk("rst.level", int'(level), 0);
        chk("rst.score", int'(score), 0);
        chk("rst.flags", int'({play_en, ball_serve, field_reset, game_over, victory}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_play();
        int n = 0;
        while (dut_state != 3'd2 && n < 20) begin
            cyc();
            n++;
        end
        chk("wait_play", int'(dut_state), S_PLAY);
    endtask

    task automatic press_start();
        start_n = 1'b1;
        cyc();
        start_n = 1'b0;
        cyc();
    endtask

    initial begin
        tv[0]  = v(0, 6'h3F, 0, 0, S_SERVE, 3, 0, 0, 1, 0);
        tv[1]  = v(0, 6'h3F, 0, 0, S_SERVE, 3, 0, 0, 0, 0);
        tv[2]  = v(0, 6'h3F, 0, 0, S_SERVE, 3, 0, 0, 0, 0);
        tv[3]  = v(0, 6'h3F, 0, 0, S_SERVE, 3, 0, 0, 0, 0);
        tv[4]  = v(0, 6'h3F, 0, 0, S_PLAY,  3, 0, 0, 0, 1);
        tv[5]  = v(0, 6'h3F, 0, 0, S_PLAY,  3, 0, 0, 0, 0);
        tv[6]  = v(0, 6'h34, 0, 0, S_PLAY,  3, 0, 3, 0, 0);
        tv[7]  = v(0, 6'h34, 0, 0, S_PLAY,  3, 0, 3, 0, 0);
        tv[8]  = v(0, 6'h00, 0, 0, S_SERVE, 3, 1, 6, 1, 0);
        tv[9]  = v(0, 6'h3F, 0, 0, S_SERVE, 3, 1, 6, 0, 0);
        tv[10] = v(0, 6'h3F, 0, 0, S_SERVE, 3, 1, 6, 0, 0);
        tv[11] = v(0, 6'h3F, 0, 0, S_SERVE, 3, 1, 6, 0, 0);
        tv[12] = v(0, 6'h3F, 0, 0, S_PLAY,  3, 1, 6, 0, 1);
        tv[13] = v(0, 6'h3E, 0, 0, S_PLAY,  3, 1, 8, 0, 0);
        tv[14] = v(0, 6'h3C, 0, 1, S_SERVE, 2, 1, 10, 0, 0);
        tv[15] = v(0, 6'h3C, 0, 0, S_SERVE, 2, 1, 10, 0, 0);
        tv[16] = v(0, 6'h3C, 0, 0, S_SERVE, 2, 1, 10, 0, 0);
        tv[17] = v(0, 6'h3C, 0, 0, S_SERVE, 2, 1, 10, 0, 0);
        tv[18] = v(0, 6'h3C, 0, 0, S_PLAY,  2, 1, 10, 0, 1);
        tv[19] = v(0, 6'h3C, 6'h10, 1, S_LOSE, 2, 1, 10, 0, 0);
        tv[20] = v(1, 6'h3C, 0, 0, S_LOSE,  2, 1, 10, 0, 0);
        tv[21] = v(0, 6'h3C, 0, 0, S_SERVE, 3, 0, 0, 1, 0);

        model_reset();
        do_reset();

        // Directed table: start/serve timing, scoring, level-up, lost ball, death zone, restart.
        for (int i = 0; i < 22; i++) begin
            start_n = tv[i].sn;
            brick_exist = tv[i].ex;
            brick_death_zone = tv[i].dz;
            ball_lost = tv[i].bl;
            cyc();
            chk($sformatf("tv%0d.state", i), int'(dut_state), tv[i].st);
            chk($sformatf("tv%0d.lives", i), int'(lives), tv[i].lv);
            chk($sformatf("tv%0d.level", i), int'(level), tv[i].lvl);
            chk($sformatf("tv%0d.score", i), int'(score), tv[i].sc);
            chk($sformatf("tv%0d.field_reset", i), int'(field_reset), int'(tv[i].fr));
            chk($sformatf("tv%0d.ball_serve", i), int'(ball_serve), int'(tv[i].bs));
        end
        brick_death_zone = '0;
        ball_lost = 1'b0;

        // Lives run out over three lost balls; ball_lost outside PLAY is ignored.
        brick_exist = '1;
        wait_play();
        ball_lost = 1'b1;
        cyc();
        chk("lost1.lives", int'(lives), 2);
        cyc();
        chk("lost_in_serve.lives", int'(lives), 2);
        ball_lost = 1'b0;
        wait_play();
        ball_lost = 1'b1;
        cyc();
        ball_lost = 1'b0;
        chk("lost2.lives", int'(lives), 1);
        wait_play();
        ball_lost = 1'b1;
        cyc();
        cyc();
        ball_lost = 1'b0;
        chk("lost3.lives", int'(lives), 0);
        chk("lost3.state", int'(dut_state), S_LOSE);
        chk("lost3.game_over", int'(game_over), 1);
        press_start();
        chk("restart.lives", int'(lives), ML);
        chk("restart.score", int'(score), 0);
        chk("restart.state", int'(dut_state), S_SERVE);

        // Two full clears reach WIN.
        wait_play();
        brick_exist = '0;
        cyc();
        chk("clear1.level", int'(level), 1);
        chk("clear1.field_reset", int'(field_reset), 1);
        brick_exist = '1;
        wait_play();
        brick_exist = '0;
        cyc();
        chk("clear2.state", int'(dut_state), S_WIN);
        chk("clear2.victory", int'(victory), 1);
        brick_exist = '1;
        press_start();
        chk("win_restart.state", int'(dut_state), S_SERVE);

        // Score saturation; a start press during PLAY is ignored.
        wait_play();
        brick_exist = '0;
        cyc();
        brick_exist = '1;
        wait_play();
        press_start();
        chk("press_in_play.state", int'(dut_state), S_PLAY);
        brick_exist = 6'h3E; cyc();
        brick_exist = 6'h3C; cyc();
        brick_exist = 6'h38; cyc();
        brick_exist = 6'h30; cyc();
        chk("pre_sat.score", int'(score), 14);
        brick_exist = 6'h20; cyc();
        chk("sat.score", int'(score), SMAX);
        brick_exist = 6'h3F; cyc();
        brick_exist = 6'h3C; cyc();
        chk("sat_hold.score", int'(score), SMAX);
        chk("sat_hold.state", int'(dut_state), S_PLAY);

        // Randomized play against the model, including mid-game resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) start_n = ~start_n;
            if (m_fr || $urandom_range(0, 39) == 0) brick_exist = '1;
            else if ($urandom_range(0, 3) == 0)
                brick_exist = brick_exist & ~(NB'($urandom) & NB'($urandom));
            ball_lost = ($urandom_range(0, 29) == 0);
            brick_death_zone = ($urandom_range(0, 149) == 0) ? NB'(1 << $urandom_range(0, NB - 1)) : '0;
            cyc();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
